// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite master bridge: one native request at a time onto AW/W/B or AR/R,
// with an optional response timeout that still drains the AXI side legally.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned PROT_WIDTH     = 3,
  parameter int unsigned RESP_WIDTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  arestn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  input  logic [PROT_WIDTH-1:0] req_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [RESP_WIDTH-1:0] rsp_resp,
  output logic                  rsp_timeout,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [PROT_WIDTH-1:0] m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [RESP_WIDTH-1:0] m_axi_bresp,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [PROT_WIDTH-1:0] m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m_axi_rresp
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic                  bready_q, bready_d, rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [PROT_WIDTH-1:0] prot_q, prot_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RESP_WIDTH-1:0] rsp_resp_q, rsp_resp_d;
  logic                  is_wr_q, is_wr_d, drain_rsp_q, drain_rsp_d;
  logic                  set_to;

  logic aw_hs_c, w_hs_c, ar_hs_c, b_hs_c, r_hs_c, rsp_hs_c, busy_c, to_hit_c;

  assign aw_hs_c  = awvalid_q & m_axi_awready;
  assign w_hs_c   = wvalid_q & m_axi_wready;
  assign ar_hs_c  = arvalid_q & m_axi_arready;
  assign b_hs_c   = bready_q & m_axi_bvalid;
  assign r_hs_c   = rready_q & m_axi_rvalid;
  assign rsp_hs_c = rsp_valid_q & rsp_ready;
  assign busy_c   = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                    (state_q == RD_REQ) || (state_q == RD_RESP);

  // Counter holds cycles elapsed since acceptance; it freezes once outside the busy states.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && state_d != IDLE) cnt_d = CNT_W'(1);
      else if (busy_c)                        cnt_d = cnt_q + CNT_W'(1);
      else if (state_d == IDLE)               cnt_d = '0;
    end

    always_ff @(posedge aclk or negedge arestn) begin
      if (!arestn) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign to_hit_c = busy_c && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_timeout
    assign to_hit_c = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    prot_d        = prot_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    is_wr_d       = is_wr_q;
    drain_rsp_d   = drain_rsp_q;
    set_to        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          addr_d      = req_addr;
          prot_d      = req_prot;
          is_wr_d     = req_write;
          if (req_write) begin
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs_c) awvalid_d = 1'b0;
        if (w_hs_c)  wvalid_d  = 1'b0;
        if (to_hit_c) set_to = 1'b1;
        else if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs_c) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (to_hit_c) set_to = 1'b1;
      end
      RD_REQ: begin
        if (ar_hs_c) arvalid_d = 1'b0;
        if (to_hit_c) set_to = 1'b1;
        else if (ar_hs_c) begin
          rready_d = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (r_hs_c) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_rresp;
          rsp_rdata_d   = m_axi_rdata;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end else if (to_hit_c) set_to = 1'b1;
      end
      RSP: begin
        if (rsp_hs_c) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DRAIN: begin
        // Finish outstanding address/data handshakes, then swallow the late response.
        if (aw_hs_c) awvalid_d = 1'b0;
        if (w_hs_c)  wvalid_d  = 1'b0;
        if (ar_hs_c) arvalid_d = 1'b0;
        if (b_hs_c || r_hs_c) begin
          drain_rsp_d = 1'b0;
          bready_d    = 1'b0;
          rready_d    = 1'b0;
        end else if (!awvalid_d && !wvalid_d && !arvalid_d && drain_rsp_q) begin
          bready_d = is_wr_q;
          rready_d = !is_wr_q;
        end
        if (rsp_hs_c) rsp_valid_d = 1'b0;
        if (!awvalid_d && !wvalid_d && !arvalid_d && !drain_rsp_d && !rsp_valid_d) begin
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (set_to) begin
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      drain_rsp_d   = 1'b1;
      state_d       = DRAIN;
    end
  end

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      prot_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      is_wr_q       <= 1'b0;
      drain_rsp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      prot_q        <= prot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      is_wr_q       <= is_wr_d;
      drain_rsp_q   <= drain_rsp_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = (TIMEOUT_CYCLES > 0) ? rsp_timeout_q : 1'b0;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = prot_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = prot_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge: scripted AXI slave, response scoreboard.
module tb_axi_lite_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned PW = 3;
  localparam int unsigned RW = 2;
  localparam int unsigned TO = 16;

  logic          aclk = 1'b0;
  logic          arestn = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_wstrb;
  logic [PW-1:0] req_prot;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [RW-1:0] rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [PW-1:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic [RW-1:0] bresp, rresp;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [RW-1:0] resp;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  axi_lite_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .PROT_WIDTH(PW),
    .RESP_WIDTH(RW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .arestn(arestn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] s, input logic [PW-1:0] p);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_prot  = p;
    tick(1);
    req_valid = 1'b0;
  endtask

  // Response monitor: every accepted native response must match the scoreboard head.
  always @(negedge aclk) begin
    if (arestn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check("rsp_spurious", 64'(rsp_valid), 64'd0);
      else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_resp", 64'(rsp_resp), 64'(mon_e.resp));
        check("rsp_timeout", 64'(rsp_timeout), 64'(mon_e.to));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_prot = '0;
    rsp_ready = 1; awready = 0; wready = 0; bvalid = 0; bresp = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0;

    tick(3);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'd0);
    check("rst_addr", 64'({awaddr, araddr}), 64'd0);
    arestn = 1'b1;
    tick(1);

    // Write: wready in cycle 1, awready in cycle 3
    send(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b001);
    check("wr_valids_c1", 64'({awvalid, wvalid}), 64'b11);
    check("wr_awaddr", 64'(awaddr), 64'h1000);
    check("wr_wdata", 64'(wdata), 64'hDEAD_BEEF);
    check("wr_wstrb", 64'(wstrb), 64'hF);
    check("wr_awprot", 64'(awprot), 64'd1);
    wready = 1; tick(1); wready = 0;
    check("wr_valids_c2", 64'({awvalid, wvalid}), 64'b10);
    tick(1);
    check("wr_awvalid_c3", 64'(awvalid), 64'd1);
    awready = 1; tick(1); awready = 0;
    check("wr_valids_c4", 64'({awvalid, wvalid}), 64'b00);
    check("wr_bready", 64'(bready), 64'd1);
    bvalid = 1; bresp = 2'b00;
    sb_q.push_back('{rdata: '0, resp: 2'b00, to: 1'b0});
    tick(1); bvalid = 0;
    check("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("wr_bready_off", 64'(bready), 64'd0);
    tick(1);
    check("wr_idle", 64'({req_ready, rsp_valid}), 64'b10);

    // Read: arready immediate, rvalid four cycles later
    send(1'b0, 32'h0000_2004, '0, '0, 3'b010);
    check("rd_arvalid", 64'(arvalid), 64'd1);
    check("rd_araddr", 64'(araddr), 64'h2004);
    check("rd_arprot", 64'(arprot), 64'd2);
    arready = 1; tick(1); arready = 0;
    check("rd_arvalid_off", 64'(arvalid), 64'd0);
    check("rd_rready", 64'(rready), 64'd1);
    tick(3);
    rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
    sb_q.push_back('{rdata: 32'h1234_5678, resp: 2'b00, to: 1'b0});
    tick(1); rvalid = 0;
    check("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    tick(1);
    check("rd_idle", 64'(req_ready), 64'd1);

    // Read with SLVERR and backpressured response
    rsp_ready = 0;
    send(1'b0, 32'h0000_2008, '0, '0, 3'b000);
    arready = 1; tick(1); arready = 0;
    rvalid = 1; rdata = 32'hCAFE_0001; rresp = 2'b10;
    sb_q.push_back('{rdata: 32'hCAFE_0001, resp: 2'b10, to: 1'b0});
    tick(1); rvalid = 0; rdata = '0; rresp = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rdata", 64'(rsp_rdata), 64'hCAFE_0001);
      check("bp_resp", 64'(rsp_resp), 64'd2);
      check("bp_req_ready", 64'(req_ready), 64'd0);
      tick(1);
    end
    rsp_ready = 1;
    tick(1);
    check("bp_idle", 64'({req_ready, rsp_valid}), 64'b10);

    // Write timeout: awready withheld, late B swallowed
    send(1'b1, 32'h0000_3000, 32'h55AA_55AA, 4'h3, 3'b000);
    lat = 1;
    wready = 1; tick(1); wready = 0; lat++;
    sb_q.push_back('{rdata: '0, resp: 2'b10, to: 1'b1});
    while (!rsp_valid && lat < 40) begin
      tick(1);
      lat++;
    end
    check("to_latency", 64'(lat), 64'd16);
    check("to_awvalid_held", 64'(awvalid), 64'd1);
    tick(3);
    check("to_drain_aw", 64'({awvalid, wvalid, bready}), 64'b100);
    bvalid = 1; bresp = 2'b00;
    tick(1);
    check("to_early_b_ignored", 64'({req_ready, bready}), 64'b00);
    awready = 1; tick(1); awready = 0;
    check("to_aw_done", 64'({awvalid, bready}), 64'b01);
    tick(1); bvalid = 0;
    check("to_back_idle", 64'({req_ready, bready, rsp_valid}), 64'b100);

    // Bvalid lands on the timeout cycle: normal response wins
    send(1'b1, 32'h0000_3004, 32'h0BAD_F00D, 4'hF, 3'b000);
    awready = 1; wready = 1; tick(1); awready = 0; wready = 0;
    check("race_bready", 64'(bready), 64'd1);
    tick(13);
    bvalid = 1; bresp = 2'b00;
    sb_q.push_back('{rdata: '0, resp: 2'b00, to: 1'b0});
    tick(1); bvalid = 0;
    check("race_rsp", 64'({rsp_valid, rsp_timeout}), 64'b10);
    tick(1);
    check("race_idle", 64'(req_ready), 64'd1);

    // Asynchronous reset while arvalid is high
    send(1'b0, 32'h0000_4000, '0, '0, 3'b000);
    check("arst_arvalid_pre", 64'(arvalid), 64'd1);
    #2 arestn = 1'b0;
    #1;
    check("arst_arvalid_drop", 64'(arvalid), 64'd0);
    check("arst_req_ready", 64'({req_ready, rsp_valid}), 64'b10);
    @(negedge aclk) arestn = 1'b1;
    tick(3);
    check("arst_after", 64'({req_ready, rsp_valid, arvalid, rready}), 64'b1000);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
Parametrised AXI4-Lite master that converts a simple single-request native port (CPU load/store unit or DMA control) into full AW/W/B and AR/R channel traffic. One transaction is outstanding at a time. AW and W are handshaked independently. An optional response timeout reports a hung slave without violating AXI valid/ready rules. It sits between core-side bus logic and the AXI interconnect.

Parameters:
ADDR_WIDTH, 32, address width of req_addr, m_axi_awaddr and m_axi_araddr.
DATA_WIDTH, 32, data width; must be 32 or 64.
STRB_WIDTH, DATA_WIDTH/8, write strobe width.
PROT_WIDTH, 3, AxPROT width.
RESP_WIDTH, 2, xRESP width.
TIMEOUT_CYCLES, 1024, cycles from request acceptance to forced timeout; 0 disables the timeout logic.

Ports:
aclk  in  1  clock; all logic on the rising edge.
arestn  in  1  asynchronous active-low reset.
req_valid  in  1  native request valid.
req_ready  out  1  native request accepted when req_valid and req_ready are both high.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  write data.
req_wstrb  in  STRB_WIDTH  write byte strobes.
req_prot  in  PROT_WIDTH  protection bits, driven to AWPROT or ARPROT.
rsp_valid  out  1  response valid; held until rsp_ready.
rsp_ready  in  1  response accept.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
rsp_resp  out  RESP_WIDTH  BRESP or RRESP; 2'b10 on timeout.
rsp_timeout  out  1  1 = response produced by timeout.
m_axi_awvalid/awready/awaddr/awprot  out/in/out/out  1/1/ADDR_WIDTH/PROT_WIDTH  AW channel.
m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/DATA_WIDTH/STRB_WIDTH  W channel.
m_axi_bvalid/bready/bresp  in/out/in  1/1/RESP_WIDTH  B channel.
m_axi_arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_WIDTH/PROT_WIDTH  AR channel.
m_axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_WIDTH/RESP_WIDTH  R channel.

Behaviour:
- Reset: all valid and ready outputs = 0, except req_ready = 1. rsp_* = 0. Address, data and prot outputs = 0. State = IDLE. Timeout counter = 0. Reset acts asynchronously at any point, including mid-transaction; in-flight valids drop immediately and no response is produced.
- All outputs are registered. req_ready = 1 only in IDLE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, DRAIN.
- Request accepted in cycle N: the request is latched, and in cycle N+1 either awvalid and wvalid both = 1 (write) or arvalid = 1 (read).
- WR_REQ: awvalid and wvalid deassert independently, each the cycle after its own handshake. Address and data stay stable while the corresponding valid is high. Go to WR_RESP once both handshakes are complete. If both complete in the same cycle, go to WR_RESP the next cycle.
- WR_RESP: bready = 1. On bvalid, capture bresp, set rsp_valid = 1 the next cycle, go to RSP.
- RD_REQ: arvalid held until arready, then go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata and rresp, go to RSP.
- RSP: rsp_valid held with stable payload until rsp_ready; then go to IDLE, with req_ready = 1 the next cycle.
- Back-to-back best case: 2 cycles of native overhead plus AXI latency. No bypass from response to the next request.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter increments each cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP, and clears on entering IDLE.
  - When counter == TIMEOUT_CYCLES-1 and the phase has not completed: rsp_valid = 1, rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0; go to DRAIN.
  - If completion and timeout occur in the same cycle, completion wins and rsp_timeout = 0.
- DRAIN: pending awvalid, wvalid and arvalid stay asserted until their handshakes, remaining legal AXI. bready or rready = 1 as applicable, and the late response is discarded. Leave to IDLE only when the AXI side is drained and the timeout response has been accepted by rsp_ready.
- TIMEOUT_CYCLES = 0: no counter is instantiated, DRAIN is unreachable, and rsp_timeout is tied to 0.
- Counter width: $clog2(TIMEOUT_CYCLES+1). No wrap is possible because the counter stops in DRAIN.
- Unused AXI ready inputs outside their phase are ignored. bvalid or rvalid arriving before the address handshake is ignored until the FSM reaches the response state.

Test Plan:
- Write 0x0000_1000/0xDEADBEEF/strb 4'hF; wready at cycle 1 and awready at cycle 3 -> each valid drops the cycle after its own handshake, bready = 1, bresp 2'b00 -> rsp_valid with rsp_resp 0, rsp_rdata 0.
- Read 0x0000_2004; arready immediate, rvalid 4 cycles later with 0x12345678 -> rsp_rdata 0x12345678, rsp_resp 0, rsp_timeout 0.
- Read with rresp 2'b10 and rsp_ready low for 5 cycles -> rsp_valid and payload stable for 5 cycles, req_ready stays 0, then IDLE.
- TIMEOUT_CYCLES = 16, write with awready never asserted -> at request +16 cycles, rsp_timeout = 1 and rsp_resp 2'b10. awvalid stays 1 until awready is finally given. A later bvalid is consumed silently, then req_ready = 1.
- bvalid coincides with the timeout cycle -> normal response, rsp_timeout = 0.
- arestn pulled low while arvalid = 1 -> arvalid drops asynchronously. After release: req_ready = 1, rsp_valid = 0, and no spurious response.
